// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter
//
// Shares one single-port synchronous BRAM (one-cycle read latency) between
// two requesters using round-robin arbitration. Commands (read or write)
// arrive over a valid/ready handshake. Read data comes back on a per-port
// one-cycle response strobe, in acceptance order, three edges after accept.
//
// Ports
//   clka                 clock, all logic on posedge
//   rst_n                asynchronous active-low reset
//   reqN_valid/ready     command handshake for requester N (N = 0, 1)
//   reqN_we              1 = write, 0 = read
//   reqN_addr/wdata      command address and write data
//   rspN_valid           one-cycle strobe: rspN_rdata holds read data
//   rspN_rdata           read data, holds between responses
//   bram_we/addr/din     registered drive of the BRAM write-enable/address/data
//   bram_dout            BRAM read data (valid one cycle after addr is sampled)
// ---------------------------------------------------------------------------
module bram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clka,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    // Port granted by the most recent accepted command (1 = port 1).
    // Resetting to 1 makes port 0 the first winner under contention.
    logic              last;

    logic              gnt0;
    logic              gnt1;
    logic              acc_p0;
    logic              win_we_p0;
    logic [ADDR_W-1:0] win_addr_p0;
    logic [DATA_W-1:0] win_wdata_p0;

    // Tag pipe: {valid, is_read, port} follows each command to the capture.
    logic              vld_p1;
    logic              rd_p1;
    logic              port_p1;
    logic              vld_p2;
    logic              rd_p2;
    logic              port_p2;

    logic              cap0_p2;
    logic              cap1_p2;

    // ---- Stage 0: arbitration (combinational) ----
    // A port is granted when it alone is valid, or when both are valid and
    // it was not the last winner. rst_n gates the readies so nothing is
    // accepted while reset is asserted.
    always_comb begin
        gnt0         = rst_n & req0_valid & (~req1_valid | last);
        gnt1         = rst_n & req1_valid & (~req0_valid | ~last);
        acc_p0       = gnt0 | gnt1;
        win_we_p0    = gnt1 ? req1_we    : req0_we;
        win_addr_p0  = gnt1 ? req1_addr  : req0_addr;
        win_wdata_p0 = gnt1 ? req1_wdata : req0_wdata;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // ---- Stage 1: issue to BRAM, record tag ----
    // Without an accept, only bram_we drops; address and data hold so the
    // BRAM port does not toggle needlessly.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            last      <= 1'b1;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            vld_p1    <= 1'b0;
            rd_p1     <= 1'b0;
            port_p1   <= 1'b0;
        end else begin
            vld_p1  <= acc_p0;
            rd_p1   <= ~win_we_p0;
            port_p1 <= gnt1;
            if (acc_p0) begin
                last      <= gnt1;
                bram_we   <= win_we_p0;
                bram_addr <= win_addr_p0;
                bram_din  <= win_wdata_p0;
            end else begin
                bram_we   <= 1'b0;
            end
        end
    end

    // ---- Stage 2: BRAM access in progress; dout valid during this stage ----
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            rd_p2   <= 1'b0;
            port_p2 <= 1'b0;
        end else begin
            vld_p2  <= vld_p1;
            rd_p2   <= rd_p1;
            port_p2 <= port_p1;
        end
    end

    assign cap0_p2 = vld_p2 & rd_p2 & ~port_p2;
    assign cap1_p2 = vld_p2 & rd_p2 &  port_p2;

    // ---- Stage 3: capture read data into the owning port's response ----
    // The non-owning port's rdata holds its previous value.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= cap0_p2;
            rsp1_valid <= cap1_p2;
            if (cap0_p2) begin
                rsp0_rdata <= bram_dout;
            end
            if (cap1_p2) begin
                rsp1_rdata <= bram_dout;
            end
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_arbiter
//
// Directed bench for bram_arbiter with a read-first single-port BRAM model.
// A negedge monitor logs grants and responses with a cycle stamp; the main
// sequence drives commands and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_bram_arbiter;

    logic        clka;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we;
    logic [15:0] req0_addr;
    logic [7:0]  req0_wdata;
    logic        rsp0_valid;
    logic [7:0]  rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [15:0] req1_addr;
    logic [7:0]  req1_wdata;
    logic        rsp1_valid;
    logic [7:0]  rsp1_rdata;
    logic        bram_we;
    logic [15:0] bram_addr;
    logic [7:0]  bram_din;
    logic [7:0]  bram_dout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         cyc;
        int         port;
        logic [7:0] data;
    } ev_t;

    ev_t g_q[$];
    ev_t r_q[$];

    bram_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .clka       (clka),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Read-first BRAM model with a side preload port.
    logic [7:0]  mem [0:65535];
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;

    always @(posedge clka) begin
        if (pl_en)        mem[pl_addr]   <= pl_data;
        else if (bram_we) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
    end

    always @(posedge clka) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clka) begin
        check("rdy_onehot", 32'(req0_ready & req1_ready), 32'd0);
        check("rdy0_novld", 32'(req0_ready & ~req0_valid), 32'd0);
        check("rdy1_novld", 32'(req1_ready & ~req1_valid), 32'd0);
        if (rst_n) begin
            if (req0_valid && req0_ready) g_q.push_back('{cyc, 0, 8'h00});
            if (req1_valid && req1_ready) g_q.push_back('{cyc, 1, 8'h00});
            if (rsp0_valid) r_q.push_back('{cyc, 0, rsp0_rdata});
            if (rsp1_valid) r_q.push_back('{cyc, 1, rsp1_rdata});
        end
    end

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    task automatic clear_logs();
        g_q.delete();
        r_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(bram_we),    32'd0);
        check({tag, "_addr"},  32'(bram_addr),  32'd0);
        check({tag, "_din"},   32'(bram_din),   32'd0);
        check({tag, "_rv0"},   32'(rsp0_valid), 32'd0);
        check({tag, "_rd0"},   32'(rsp0_rdata), 32'd0);
        check({tag, "_rv1"},   32'(rsp1_valid), 32'd0);
        check({tag, "_rd1"},   32'(rsp1_rdata), 32'd0);
        check({tag, "_rdy0"},  32'(req0_ready), 32'd0);
        check({tag, "_rdy1"},  32'(req1_ready), 32'd0);
    endtask

    initial begin
        int idx0, idx1;
        logic a0, a1;
        logic        bw_we [4];
        logic [7:0]  bw_d  [4];

        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'h0; req0_wdata = 8'h0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 16'h0; req1_wdata = 8'h0;

        // Power-on reset with both valids high: readies must stay low.
        drain(2);
        check_all_zero("por");
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        preload(16'h0000, 8'h10);
        preload(16'h0001, 8'h11);
        preload(16'h0002, 8'h12);
        preload(16'h0100, 8'h20);
        preload(16'h0101, 8'h21);
        preload(16'h0102, 8'h22);
        preload(16'hFFFF, 8'h77);

        // Round-robin contention: both ports read three addresses each.
        clear_logs();
        idx0 = 0; idx1 = 0;
        req0_we = 1'b0; req1_we = 1'b0;
        for (int c = 0; c < 10 && (idx0 < 3 || idx1 < 3); c++) begin
            req0_valid = (idx0 < 3); req0_addr = 16'(idx0);
            req1_valid = (idx1 < 3); req1_addr = 16'h0100 + 16'(idx1);
            #1;
            a0 = req0_ready; a1 = req1_ready;
            step();
            if (a0) idx0++;
            if (a1) idx1++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain(5);
        check("rr_ngrant", 32'(g_q.size()), 32'd6);
        for (int i = 0; i < g_q.size() && i < 6; i++) begin
            check($sformatf("rr_gport%0d", i), 32'(g_q[i].port), 32'(i % 2));
            if (i > 0) check($sformatf("rr_gcyc%0d", i), 32'(g_q[i].cyc - g_q[i-1].cyc), 32'd1);
        end
        check("rr_nrsp", 32'(r_q.size()), 32'd6);
        for (int i = 0; i < r_q.size() && i < 6; i++) begin
            check($sformatf("rr_rport%0d", i), 32'(r_q[i].port), 32'(i % 2));
            check($sformatf("rr_rdata%0d", i), 32'(r_q[i].data),
                  (i % 2 == 0) ? 32'h10 + 32'(i / 2) : 32'h20 + 32'(i / 2));
            if (i < g_q.size())
                check($sformatf("rr_lat%0d", i), 32'(r_q[i].cyc - g_q[i].cyc), 32'd3);
        end

        // Single port: write 0xA5 to 0x1234, then read it back.
        clear_logs();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 16'h1234; req0_wdata = 8'hA5;
        #1;
        check("sp_wr_rdy0", 32'(req0_ready), 32'd1);
        check("sp_wr_rdy1", 32'(req1_ready), 32'd0);
        step();
        check("sp_bram_we",   32'(bram_we),   32'd1);
        check("sp_bram_addr", 32'(bram_addr), 32'h1234);
        check("sp_bram_din",  32'(bram_din),  32'hA5);
        req0_we = 1'b0;
        #1;
        check("sp_rd_rdy0", 32'(req0_ready), 32'd1);
        step();
        check("sp_we_pulse", 32'(bram_we),   32'd0);
        check("sp_rd_addr",  32'(bram_addr), 32'h1234);
        req0_valid = 1'b0;
        drain(5);
        check("sp_ngrant", 32'(g_q.size()), 32'd2);
        check("sp_nrsp",   32'(r_q.size()), 32'd1);
        if (r_q.size() > 0 && g_q.size() > 1) begin
            check("sp_rport", 32'(r_q[0].port), 32'd0);
            check("sp_rdata", 32'(r_q[0].data), 32'hA5);
            check("sp_lat",   32'(r_q[0].cyc - g_q[1].cyc), 32'd3);
        end

        // Port 1 back-to-back W/R/W/R to 0x00FF.
        clear_logs();
        bw_we[0] = 1'b1; bw_d[0] = 8'h3C;
        bw_we[1] = 1'b0; bw_d[1] = 8'h00;
        bw_we[2] = 1'b1; bw_d[2] = 8'hC3;
        bw_we[3] = 1'b0; bw_d[3] = 8'h00;
        req1_addr = 16'h00FF;
        for (int i = 0; i < 4; i++) begin
            req1_valid = 1'b1; req1_we = bw_we[i]; req1_wdata = bw_d[i];
            #1;
            check($sformatf("bb_rdy%0d", i), 32'(req1_ready), 32'd1);
            step();
        end
        req1_valid = 1'b0;
        drain(5);
        check("bb_nrsp", 32'(r_q.size()), 32'd2);
        if (r_q.size() > 1 && g_q.size() > 1) begin
            check("bb_port0", 32'(r_q[0].port), 32'd1);
            check("bb_data0", 32'(r_q[0].data), 32'h3C);
            check("bb_data1", 32'(r_q[1].data), 32'hC3);
            check("bb_gap",   32'(r_q[1].cyc - r_q[0].cyc), 32'd2);
            check("bb_lat",   32'(r_q[0].cyc - g_q[1].cyc), 32'd3);
        end
        check("bb_rd0_hold", 32'(rsp0_rdata), 32'hA5);

        // Fairness: port 0 alone for three accepts, then contention.
        clear_logs();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("fair_alone%0d", i), 32'(req0_ready), 32'd1);
            step();
        end
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 16'h0100;
        #1;
        check("fair_p1_first", 32'(req1_ready), 32'd1);
        check("fair_p0_wait",  32'(req0_ready), 32'd0);
        step();
        check("fair_p0_next",  32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain(5);
        check("fair_nrsp", 32'(r_q.size()), 32'd5);

        // Address wrap: 0xFFFF then 0x0000.
        clear_logs();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'hFFFF;
        step();
        req0_addr = 16'h0000;
        step();
        req0_valid = 1'b0;
        drain(5);
        check("wrap_nrsp", 32'(r_q.size()), 32'd2);
        if (r_q.size() > 1) begin
            check("wrap_ffff", 32'(r_q[0].data), 32'h77);
            check("wrap_0000", 32'(r_q[1].data), 32'h10);
        end

        // Reset mid-stream with port 0 reads in flight.
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'h0001;
        step();
        step();
        req1_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        drain(2);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        clear_logs();
        drain(4);
        check("post_rst_norsp", 32'(r_q.size()), 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_addr = 16'h0000; req1_addr = 16'h0100;
        #1;
        check("post_rst_p0", 32'(req0_ready), 32'd1);
        check("post_rst_p1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
